// File: rtl/t02_spi_arbiter.sv
// rtl/t02_spi_arbiter.sv - round-robin arbiter sharing one SPI master among three requesters
// Supports locked back-to-back bursts, per-frame timeout and nbits clamping.
module t02_spi_arbiter #(
  parameter int NBITS_MAX = 16,
  parameter int TIMEOUT   = 4096,
  parameter int BURST_MAX = 4
) (
  input  logic                 hz100,
  input  logic                 reset,
  input  logic [2:0]           req,
  input  logic [2:0]           lock,
  input  logic [NBITS_MAX-1:0] wdata0,
  input  logic [NBITS_MAX-1:0] wdata1,
  input  logic [NBITS_MAX-1:0] wdata2,
  input  logic [4:0]           nbits0,
  input  logic [4:0]           nbits1,
  input  logic [4:0]           nbits2,
  output logic [2:0]           gnt,
  output logic [2:0]           done,
  output logic                 err,
  output logic [NBITS_MAX-1:0] rdata,
  output logic                 mst_start,
  output logic [NBITS_MAX-1:0] mst_data,
  output logic [4:0]           mst_nbits,
  output logic [2:0]           mst_cs_sel,
  input  logic                 mst_done,
  input  logic [NBITS_MAX-1:0] mst_rdata
);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int BW = $clog2(BURST_MAX + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t               state_q, state_d;
  logic [1:0]           rr_ptr, win_q, pick, latch_idx;
  logic [BW-1:0]        burst_q;
  logic [TW-1:0]        tcnt_q;
  logic                 tout_q, latch, cont, tout_hit, other_pending;
  logic [2:0]           win_oh;
  logic [NBITS_MAX-1:0] sel_data;
  logic [4:0]           sel_nbits, raw_nbits;

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Round-robin search: rr_ptr first, then the two that follow it.
  always_comb begin
    if (req[rr_ptr])                          pick = rr_ptr;
    else if (req[next_idx(rr_ptr)])           pick = next_idx(rr_ptr);
    else                                      pick = next_idx(next_idx(rr_ptr));
  end

  assign win_oh        = 3'b001 << win_q;
  assign other_pending = |(req & ~win_oh);
  assign tout_hit      = (tcnt_q == TW'(TIMEOUT - 1));
  // A saturated burst keeps going only while nobody else is waiting.
  assign cont = lock[win_q] & req[win_q] & ((burst_q < BW'(BURST_MAX)) | ~other_pending);

  always_comb begin
    sel_data  = wdata2;
    raw_nbits = nbits2;
    case (latch_idx)
      2'd0: begin sel_data = wdata0; raw_nbits = nbits0; end
      2'd1: begin sel_data = wdata1; raw_nbits = nbits1; end
      default: ;
    endcase
    sel_nbits = raw_nbits;
    if (raw_nbits == 5'd0 || int'(raw_nbits) > NBITS_MAX) sel_nbits = 5'(NBITS_MAX);
  end

  always_comb begin
    state_d   = state_q;
    latch     = 1'b0;
    latch_idx = win_q;
    mst_start = 1'b0;
    done      = 3'b000;
    err       = 1'b0;
    case (state_q)
      IDLE: if (|req) begin
        latch     = 1'b1;
        latch_idx = pick;
        state_d   = START;
      end
      START: begin
        mst_start = 1'b1;
        state_d   = WAIT;
      end
      WAIT: if (mst_done || tout_hit) state_d = DONE;
      DONE: begin
        done = win_oh;
        err  = tout_q;
        if (cont) begin
          latch   = 1'b1;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hz100) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr     <= 2'd0;
      win_q      <= 2'd0;
      burst_q    <= '0;
      tcnt_q     <= '0;
      tout_q     <= 1'b0;
      gnt        <= 3'b000;
      mst_cs_sel <= 3'b000;
      mst_data   <= '0;
      mst_nbits  <= 5'd0;
      rdata      <= '0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        win_q      <= latch_idx;
        gnt        <= 3'b001 << latch_idx;
        mst_cs_sel <= 3'b001 << latch_idx;
        mst_data   <= sel_data;
        mst_nbits  <= sel_nbits;
      end
      case (state_q)
        IDLE: if (|req) burst_q <= BW'(1);
        START: begin
          tcnt_q <= '0;
          tout_q <= 1'b0;
        end
        WAIT: begin
          tcnt_q <= tcnt_q + TW'(1);
          if (mst_done)      rdata  <= mst_rdata;
          else if (tout_hit) tout_q <= 1'b1;
        end
        DONE: begin
          rr_ptr <= next_idx(win_q);
          if (cont) begin
            if (burst_q < BW'(BURST_MAX)) burst_q <= burst_q + BW'(1);
          end else begin
            burst_q    <= '0;
            gnt        <= 3'b000;
            mst_cs_sel <= 3'b000;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_t02_spi_arbiter.sv
// tb/tb_t02_spi_arbiter.sv - self-checking bench for t02_spi_arbiter
module tb_t02_spi_arbiter;
  localparam int NB = 16;
  localparam int TO = 4096;
  localparam int BM = 4;

  logic          hz100 = 1'b0;
  logic          reset;
  logic [2:0]    req, lock;
  logic [NB-1:0] wdata0, wdata1, wdata2;
  logic [4:0]    nbits0, nbits1, nbits2;
  logic [2:0]    gnt, done, mst_cs_sel;
  logic          err, mst_start, mst_done;
  logic [NB-1:0] rdata, mst_data, mst_rdata;
  logic [4:0]    mst_nbits;

  int checks = 0;
  int failures = 0;
  int m_rr, m_w, m_frames;

  t02_spi_arbiter #(.NBITS_MAX(NB), .TIMEOUT(TO), .BURST_MAX(BM)) dut (
    .hz100(hz100), .reset(reset), .req(req), .lock(lock),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .nbits0(nbits0), .nbits1(nbits1), .nbits2(nbits2),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .mst_start(mst_start), .mst_data(mst_data), .mst_nbits(mst_nbits),
    .mst_cs_sel(mst_cs_sel), .mst_done(mst_done), .mst_rdata(mst_rdata)
  );

  always #5 hz100 = ~hz100;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [2:0] r, input int ptr);
    for (int k = 0; k < 3; k++)
      if (r[(ptr + k) % 3]) return (ptr + k) % 3;
    return -1;
  endfunction

  function automatic logic [NB-1:0] exp_wdata(input int w);
    case (w)
      0:       return wdata0;
      1:       return wdata1;
      default: return wdata2;
    endcase
  endfunction

  function automatic logic [4:0] exp_nb(input int w);
    logic [4:0] raw;
    case (w)
      0:       raw = nbits0;
      1:       raw = nbits1;
      default: raw = nbits2;
    endcase
    if (raw == 5'd0 || int'(raw) > NB) return 5'(NB);
    return raw;
  endfunction

  task automatic randomize_fields();
    wdata0 = 16'($urandom); wdata1 = 16'($urandom); wdata2 = 16'($urandom);
    nbits0 = 5'($urandom_range(0, 31));
    nbits1 = 5'($urandom_range(0, 31));
    nbits2 = 5'($urandom_range(0, 31));
  endtask

  task automatic model_start();
    m_frames = 1;
    m_w      = rr_pick(req, m_rr);
  endtask

  // Called once a frame's DONE has been observed; predicts the next owner.
  task automatic model_next();
    int  w;
    bit  other;
    w     = m_w;
    m_rr  = (w + 1) % 3;
    other = (req & ~(3'b001 << w)) != 3'b000;
    if (lock[w] && req[w] && (m_frames < BM || !other)) begin
      if (m_frames < BM) m_frames++;
    end else begin
      m_w      = rr_pick(req, m_rr);
      m_frames = 1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 3'b000; lock = 3'b000; mst_done = 1'b0;
    @(negedge hz100);
    reset = 1'b0;
    m_rr  = 0;
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    while (mst_start !== 1'b1 && n < 20) begin
      @(negedge hz100);
      n++;
    end
    chk("start_seen", mst_start, 1);
  endtask

  task automatic do_frame(input int w, input int lat, input logic [NB-1:0] rd,
                          input bit early, input bit drop);
    logic [NB-1:0] ed;
    logic [4:0]    en;
    ed = exp_wdata(w);
    en = exp_nb(w);
    wait_start();
    chk("gnt", gnt, 1 << w);
    chk("cs_sel", mst_cs_sel, 1 << w);
    chk("mst_data", mst_data, ed);
    chk("mst_nbits", mst_nbits, en);
    if (early) begin mst_done = 1'b1; mst_rdata = ~rd; end
    if (drop) req[w] = 1'b0;
    @(negedge hz100);
    mst_done = 1'b0;
    chk("start_pulse", mst_start, 0);
    chk("early_ignored", done, 0);
    repeat (lat - 1) @(negedge hz100);
    mst_done = 1'b1; mst_rdata = rd;
    @(negedge hz100);
    mst_done = 1'b0;
    chk("done", done, 1 << w);
    chk("err", err, 0);
    chk("rdata", rdata, rd);
    chk("gnt_held", gnt, 1 << w);
    chk("data_held", mst_data, ed);
    randomize_fields();
    @(negedge hz100);
    chk("done_pulse", done, 0);
  endtask

  initial begin
    logic [NB-1:0] rd1;
    int n;
    reset = 1'b1; req = 3'b000; lock = 3'b000; mst_done = 1'b0; mst_rdata = '0;
    randomize_fields();
    repeat (2) @(negedge hz100);
    chk("rst_gnt", gnt, 0); chk("rst_done", done, 0); chk("rst_err", err, 0);
    chk("rst_start", mst_start, 0); chk("rst_cs", mst_cs_sel, 0);
    chk("rst_data", mst_data, 0); chk("rst_nbits", mst_nbits, 0); chk("rst_rdata", rdata, 0);
    reset = 1'b0; m_rr = 0;

    // All three requesting, no locks: strict rotation.
    req = 3'b111; lock = 3'b000; model_start();
    for (int i = 0; i < 6; i++) begin
      do_frame(m_w, $urandom_range(1, 10), 16'($urandom), i == 2, 1'b0);
      model_next();
    end

    // Directed IMU frame with 20-cycle master latency.
    do_reset();
    wdata0 = 16'hA5C3; nbits0 = 5'd16; req = 3'b001; model_start();
    do_frame(0, 20, 16'h1234, 1'b0, 1'b0);
    req = 3'b000;
    @(negedge hz100);
    chk("idle_gnt", gnt, 0);
    chk("rdata_hold", rdata, 16'h1234);

    // Locked LCD with IMU pending: bursts capped then re-arbitrated.
    do_reset();
    req = 3'b101; lock = 3'b100; model_start();
    for (int i = 0; i < 8; i++) begin
      do_frame(m_w, $urandom_range(1, 6), 16'($urandom), 1'b0, 1'b0);
      model_next();
    end

    // Locked LCD alone: burst continues past the cap.
    do_reset();
    req = 3'b100; lock = 3'b100; model_start();
    for (int i = 0; i < 6; i++) begin
      do_frame(m_w, $urandom_range(1, 6), 16'($urandom), 1'b0, 1'b0);
      model_next();
    end

    // nbits=0 clamps; req dropped mid-frame still completes.
    do_reset();
    nbits1 = 5'd0; req = 3'b010; model_start();
    do_frame(m_w, 3, 16'($urandom), 1'b0, 1'b1);
    model_next();
    chk("idle_after_drop", gnt, 0);

    // Timeout: master never answers.
    do_reset();
    req = 3'b001; model_start();
    rd1 = 16'($urandom);
    do_frame(0, 4, rd1, 1'b0, 1'b0);
    model_next();
    wait_start();
    n = 0;
    while (done === 3'b000 && n < 5000) begin
      @(negedge hz100);
      n++;
    end
    chk("timeout_cycles", n, TO + 1);
    chk("timeout_done", done, 3'b001);
    chk("timeout_err", err, 1);
    chk("timeout_rdata", rdata, rd1);
    req = 3'b000;
    @(negedge hz100);
    chk("timeout_err_pulse", err, 0);
    chk("timeout_done_pulse", done, 0);
    chk("timeout_idle", gnt, 0);

    // Reset during WAIT.
    req = 3'b010;
    wait_start();
    @(negedge hz100);
    reset = 1'b1; req = 3'b000;
    @(negedge hz100);
    chk("midrst_gnt", gnt, 0); chk("midrst_cs", mst_cs_sel, 0);
    chk("midrst_done", done, 0); chk("midrst_err", err, 0);
    chk("midrst_start", mst_start, 0); chk("midrst_data", mst_data, 0);
    reset = 1'b0;
    @(negedge hz100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/t02_spi_arbiter.md
T02_SPI_ARBITER -- requirements
Module: t02_spi_arbiter

Interface
REQ-001 SHALL have parameter NBITS_MAX, default 16, meaning the maximum frame length in bits and the width of all data buses.
REQ-002 SHALL have parameter TIMEOUT, default 4096, meaning the number of hz100 cycles allowed in WAIT before a frame is aborted.
REQ-003 SHALL have parameter BURST_MAX, default 4, meaning the maximum number of consecutive locked frames per grant.
REQ-004 SHALL have port hz100, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port req, input, 3 bits: request per requester (0=IMU, 1=IR shift chain, 2=LCD).
REQ-007 SHALL have port lock, input, 3 bits: when high, the requester asks to keep the bus for back-to-back frames.
REQ-008 SHALL have port wdata0/1/2, input, NBITS_MAX bits each: frame payload per requester.
REQ-009 SHALL have port nbits0/1/2, input, 5 bits each: frame length per requester.
REQ-010 SHALL have port gnt, output, 3 bits: one-hot grant.
REQ-011 SHALL have port done, output, 3 bits: one-cycle completion pulse, at most one bit set.
REQ-012 SHALL have port err, output, 1 bit: one-cycle timeout pulse, coincident with done.
REQ-013 SHALL have port rdata, output, NBITS_MAX bits: last captured read data.
REQ-014 SHALL have port mst_start, output, 1 bit: one-cycle start pulse to the shared SPI master.
REQ-015 SHALL have port mst_data, output, NBITS_MAX bits, and port mst_nbits, output, 5 bits: latched frame fields.
REQ-016 SHALL have port mst_cs_sel, output, 3 bits: one-hot chip-select routing.
REQ-017 SHALL have port mst_done, input, 1 bit, and port mst_rdata, input, NBITS_MAX bits: master completion and read data.

Function
REQ-018 SHALL implement the FSM IDLE -> START -> WAIT -> DONE, then DONE -> START on a locked continuation or DONE -> IDLE otherwise.
REQ-019 IDLE: when any req is high, SHALL choose the winner round-robin starting at rr_ptr, latch its wdata/nbits, set gnt and mst_cs_sel to the winner, and go to START, so gnt rises one cycle after req.
REQ-020 START: SHALL assert mst_start for exactly one cycle, then go to WAIT.
REQ-021 mst_data, mst_nbits, gnt and mst_cs_sel SHALL be held stable from START through DONE.
REQ-022 nbits of 0 or greater than NBITS_MAX SHALL be clamped to NBITS_MAX at latch time.
REQ-023 WAIT: on mst_done, SHALL capture mst_rdata into rdata and go to DONE.
REQ-024 WAIT: after TIMEOUT cycles without mst_done, SHALL go to DONE with err flagged and leave rdata unchanged.
REQ-025 DONE: SHALL pulse done[winner], and err if timed out, for one cycle, and set rr_ptr to (winner+1) mod 3.
REQ-026 DONE: if lock[winner] and req[winner] are high and the burst count is below BURST_MAX, SHALL relatch the winner's fields, increment the burst count, and go to START with gnt kept.
REQ-027 Otherwise DONE SHALL clear gnt and mst_cs_sel, clear the burst count, and go to IDLE.
REQ-028 On reaching BURST_MAX with another req pending, SHALL force re-arbitration; with no other req pending, the burst continues and the count saturates.
REQ-029 Deassertion of req mid-frame SHALL NOT abort the frame; done still pulses.
REQ-030 mst_done arriving in START, IDLE or DONE SHALL be ignored.

Reset
REQ-031 On reset, SHALL go to IDLE with rr_ptr=0, the burst and timeout counters at 0, and gnt, done, err, mst_start, mst_cs_sel, mst_data, mst_nbits and rdata all at 0.
REQ-032 Reset mid-frame SHALL drop mst_cs_sel and gnt on the next edge, with no done or err pulse.

Verification
REQ-033 req=3'b111 from reset -> grants in order 0,1,2,0, one gnt per frame, with done pulsing for the matching index.
REQ-034 req0 only, wdata0=16'hA5C3, nbits0=16, mst_done 20 cycles after mst_start with mst_rdata=16'h1234 -> mst_data=16'hA5C3, rdata=16'h1234, done=3'b001 exactly one cycle.
REQ-035 lock2=1 and req2=1 held, req0 also high -> 4 consecutive LCD frames, then grant moves to 0.
REQ-036 mst_done never asserted -> err and done pulse after 4096 WAIT cycles, then FSM returns to IDLE.
REQ-037 reset asserted during WAIT -> next cycle gnt=0, mst_cs_sel=0, done=0, err=0.
REQ-038 nbits1=0 -> mst_nbits=16.
